instr_word_encoder: RTL and testbench
=====================================

# instr_word_encoder

Sequential MIPS instruction encoder and instruction-memory loader: the inverse of the CPU's main control decoder. It accepts symbolic instruction requests (kind, register fields, immediate) over a valid/ready handshake, packs them into 32-bit MIPS words and writes them sequentially into the instruction memory's write port. It expands the `li` pseudo-instruction into `lui` + `ori` over two cycles. The bench and boot loader use it to build programs for the P4 datapath.

## Interface
Parameters:
- `IM_DEPTH`, default 1024: capacity in words; legal range 2..32768.
- `BASE_ADDR`, default 32'h0000_3000: byte address of the first word written.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous restart of the load pointer; has priority over `in_valid`.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request this cycle.
- `in_kind` in 4: 0 addu, 1 subu, 2 jr, 3 sll (nop = all-zero sll), 4 lw, 5 sw, 6 beq, 7 lui, 8 ori, 9 jal, 10 blez, 11 li; 12–15 unsupported.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` in 5 each: register and shift fields.
- `in_imm` in 32: bits [15:0] give imm16; bits [25:0] give the jal index; all 32 bits are used by li.
- `im_we` out 1: write strobe to instruction memory, one cycle per word.
- `im_addr` out 32: byte address of the word being written.
- `im_wdata` out 32: encoded word.
- `word_count` out 16: number of words written since reset or flush.
- `full` out 1: `word_count == IM_DEPTH`.
- `err` out 1: sticky error flag; cleared only by reset or flush.

## Operation
Encodings (op, rs, rt, rd, shamt, func, imm):
- addu: 0, rs, rt, rd, 0, 0x21.
- subu: 0, rs, rt, rd, 0, 0x23.
- jr: 0, rs, 0, 0, 0, 0x08.
- sll: 0, 0, rt, rd, shamt, 0x00.
- lw 0x23, sw 0x2B, beq 0x04, ori 0x0D: op, rs, rt, imm16.
- lui: 0x0F, rs=0, rt, imm16.
- blez: 0x06, rs, rt=0, imm16.
- jal: 0x03, index26.
- li: emits `lui rt, imm[31:16]`, then `ori rt, rt, imm[15:0]`.

A request is accepted on a rising edge where `in_valid && in_ready`.

FSM states:
- RUN: `in_ready=1`.
  - Accepting li → LI2.
  - Write that makes `word_count` reach IM_DEPTH → FULL.
  - Any other accept stays in RUN.
- LI2: `in_ready=0`. Writes the ori word, then → RUN, or → FULL if capacity is reached.
- FULL: `in_ready=0`, no writes. Left only by flush or reset → RUN.

Pointer rules:
- Internal `next_addr` starts at BASE_ADDR and advances by 4 per written word.
- `word_count` increments by 1 per written word.
- No wrap-around: the pointer stops at full.

Errors:
- Unsupported kind: the request is accepted, nothing is written, `err` is set.
- li accepted with exactly one free slot: the lui word is written, the ori word is dropped, `err` is set, and the FSM goes to FULL.

Flush (any state):
- Next edge: `next_addr = BASE_ADDR`, `word_count = 0`, `err = 0`, FSM → RUN.
- A pending LI2 word is discarded.
- A request presented in the same cycle as flush is not accepted.

## Timing
- Reset values: `im_we=0`, `im_addr=BASE_ADDR`, `im_wdata=0`, `word_count=0`, `full=0`, `err=0`, state RUN. `in_ready` is 1 once `reset_n` is high.
- `in_ready` is decoded combinationally from state only; it does not depend on `in_kind`.
- `im_we`, `im_addr` and `im_wdata` are registered:
  - For a request accepted at edge k, the write is presented during cycle k+1.
  - For li, the ori word is presented during cycle k+2, and `in_ready` is low during cycle k+1.
- `im_we` is high for exactly one cycle per word. When `im_we=0`, `im_addr` and `im_wdata` hold their last values.
- `full` and `err` assert in the same cycle as the write or accept that causes them.
- Back-to-back non-li requests sustain one word per cycle.
- Reset asserted mid-li: all outputs take reset values immediately, and no ori word is ever emitted.

## Test plan
- addu rd=3, rs=1, rt=2 after reset → one-cycle `im_we`, `im_addr=0x3000`, `im_wdata=0x00221821`, `word_count=1`.
- ori rt=1, rs=0, imm=0x1234, then blez rs=4, imm=0xFFFE, then jal imm=0x0000C03, presented back-to-back → `0x34011234` @0x3000, `0x1880FFFE` @0x3004, `0x0C000C03` @0x3008 on consecutive cycles.
- li rt=8, imm=0xDEADBEEF → `0x3C08DEAD` @0x3000, then `0x3508BEEF` @0x3004; `in_ready=0` for exactly one cycle; a following request is written @0x3008.
- IM_DEPTH=4, four nops → all-zero words @0x3000..0x300C, then `full=1` and `in_ready=0`. A fifth held `in_valid` produces no write. Flush → `full=0`, `word_count=0`, next write @0x3000.
- IM_DEPTH=3, two nops then li → lui written @0x3008, no ori, `err=1`, `full=1`. After flush, kind 15 → no `im_we`, `err=1`, `word_count=0`.
- li accepted, then `reset_n` pulsed low during the cycle the lui word is presented → outputs at reset values, no ori word emitted, next request written @0x3000.

Source files
------------

// File: rtl/instr_word_encoder.sv
// MIPS instruction encoder that streams packed words into instruction memory.
// Latency: one cycle from accept to write; li takes two write cycles.
// Backpressure: in_ready is low while the ori half of li is pending and when memory is full.
module instr_word_encoder #(
    parameter int unsigned IM_DEPTH  = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_imm,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic [15:0] word_count,
    output logic        full,
    output logic        err
);

    typedef enum logic [1:0] {RUN, LI2, FULL_ST} state_t;

    localparam logic [15:0] DEPTH_W = 16'(IM_DEPTH);

    state_t      state, state_nx;
    logic [31:0] next_addr;
    logic [4:0]  li_rt;
    logic [15:0] li_lo;
    logic [31:0] enc_word, wr_word;
    logic        enc_ok, enc_li, accept, last_slot, do_write, err_set;

    assign in_ready  = (state == RUN);
    assign accept    = in_valid && in_ready && !flush;
    assign last_slot = (word_count == DEPTH_W - 16'd1);
    assign full      = (word_count == DEPTH_W);

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        enc_li   = 1'b0;
        case (in_kind)
            4'd0:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
            4'd1:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
            4'd2:  enc_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
            4'd3:  enc_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
            4'd4:  enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
            4'd5:  enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
            4'd6:  enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
            4'd7:  enc_word = {6'h0F, 5'd0, in_rt, in_imm[15:0]};
            4'd8:  enc_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
            4'd9:  enc_word = {6'h03, in_imm[25:0]};
            4'd10: enc_word = {6'h06, in_rs, 5'd0, in_imm[15:0]};
            4'd11: begin
                enc_word = {6'h0F, 5'd0, in_rt, in_imm[31:16]};
                enc_li   = 1'b1;
            end
            default: enc_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        do_write = 1'b0;
        wr_word  = enc_word;
        err_set  = 1'b0;
        case (state)
            RUN: begin
                if (accept && enc_ok) begin
                    do_write = 1'b1;
                    if (last_slot) begin
                        state_nx = FULL_ST;
                        err_set  = enc_li;
                    end else if (enc_li) begin
                        state_nx = LI2;
                    end
                end else if (accept) begin
                    err_set = 1'b1;
                end
            end
            LI2: begin
                do_write = 1'b1;
                wr_word  = {6'h0D, li_rt, li_rt, li_lo};
                state_nx = last_slot ? FULL_ST : RUN;
            end
            default: ;
        endcase
        if (flush) begin
            state_nx = RUN;
            do_write = 1'b0;
            err_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_we      <= 1'b0;
            im_addr    <= BASE_ADDR;
            im_wdata   <= '0;
            next_addr  <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            li_rt      <= '0;
            li_lo      <= '0;
        end else if (flush) begin
            im_we      <= 1'b0;
            next_addr  <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            im_we <= do_write;
            if (do_write) begin
                im_addr    <= next_addr;
                im_wdata   <= wr_word;
                next_addr  <= next_addr + 32'd4;
                word_count <= word_count + 16'd1;
            end
            if (err_set) err <= 1'b1;
            // Low half of li is parked until the LI2 cycle emits the ori word.
            if (accept && enc_li) begin
                li_rt <= in_rt;
                li_lo <= in_imm[15:0];
            end
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
module tb_instr_word_encoder;
    localparam int DEPTH = 6;
    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk, reset_n, flush, in_valid, in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm, im_addr, im_wdata;
    logic        im_we, full, err;
    logic [15:0] word_count;

    instr_word_encoder #(.IM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .word_count(word_count), .full(full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cnt;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    bit          started = 0;
    bit          exp_we = 0;
    int          m_cnt = 0;
    bit          m_err = 0, m_pend = 0;
    logic [31:0] m_pword = '0;

    function automatic logic [31:0] rfmt(int op, int rs, int rt, int rd, int sh, int fn);
        return (32'(op) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + (32'(sh) << 6) + 32'(fn);
    endfunction

    function automatic logic [31:0] ifmt(int op, int rs, int rt, logic [31:0] imm);
        return (32'(op) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + (imm & 32'hFFFF);
    endfunction

    function automatic bit m_ready();
        return !m_pend && (m_cnt < DEPTH);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_word(logic [31:0] w);
        exp_t e;
        e.addr = BASE + 32'(4 * m_cnt);
        e.data = w;
        e.cnt  = m_cnt + 1;
        q.push_back(e);
        m_cnt++;
        exp_we = 1;
    endtask

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_pend = 0; exp_we = 0;
    endtask

    // Reference behaviour for one rising edge, from the visible inputs.
    task automatic model_edge();
        int rs, rt, rd, sh;
        exp_we = 0;
        rs = int'(in_rs); rt = int'(in_rt); rd = int'(in_rd); sh = int'(in_shamt);
        if (!reset_n || flush) begin
            model_clear();
        end else if (m_pend) begin
            push_word(m_pword);
            m_pend = 0;
        end else if (in_valid && m_ready()) begin
            case (int'(in_kind))
                0:  push_word(rfmt(0, rs, rt, rd, 0, 'h21));
                1:  push_word(rfmt(0, rs, rt, rd, 0, 'h23));
                2:  push_word(rfmt(0, rs, 0, 0, 0, 'h08));
                3:  push_word(rfmt(0, 0, rt, rd, sh, 0));
                4:  push_word(ifmt('h23, rs, rt, in_imm));
                5:  push_word(ifmt('h2B, rs, rt, in_imm));
                6:  push_word(ifmt('h04, rs, rt, in_imm));
                7:  push_word(ifmt('h0F, 0, rt, in_imm));
                8:  push_word(ifmt('h0D, rs, rt, in_imm));
                9:  push_word((32'h3 << 26) + (in_imm & 32'h03FF_FFFF));
                10: push_word(ifmt('h06, rs, 0, in_imm));
                11: begin
                    push_word(ifmt('h0F, 0, rt, in_imm >> 16));
                    if (m_cnt == DEPTH) m_err = 1;
                    else begin
                        m_pend  = 1;
                        m_pword = ifmt('h0D, rt, rt, in_imm);
                    end
                end
                default: m_err = 1;
            endcase
        end
    endtask

    task automatic step(bit v, int k, int rs, int rt, int rd, int sh, logic [31:0] imm, bit fl);
        in_valid = v; in_kind = k[3:0]; in_rs = rs[4:0]; in_rt = rt[4:0];
        in_rd = rd[4:0]; in_shamt = sh[4:0]; in_imm = imm; flush = fl;
        if (reset_n) chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("word_count", {16'd0, word_count}, 32'(m_cnt));
        chk("full", {31'd0, full}, {31'd0, m_cnt == DEPTH});
        chk("err", {31'd0, err}, {31'd0, m_err});
        in_valid = 0; flush = 0;
    endtask

    task automatic send(int k, int rs, int rt, int rd, int sh, logic [31:0] imm);
        int n = 0;
        while (!m_ready() && n < 4) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        step(1, k, rs, rt, rd, sh, imm, 0);
    endtask

    task automatic do_flush();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic reset_chk(string tag);
        chk({tag, "_we"}, {31'd0, im_we}, 32'd0);
        chk({tag, "_addr"}, im_addr, BASE);
        chk({tag, "_wdata"}, im_wdata, 32'd0);
        chk({tag, "_count"}, {16'd0, word_count}, 32'd0);
        chk({tag, "_full"}, {31'd0, full}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // Monitor: every negedge compares the write strobe and pops one expected word per write.
    always @(negedge clk) begin
        if (started) begin
            total++;
            if (im_we !== exp_we) begin
                bad++;
                $display("FAIL im_we actual=%b required=%b t=%0t", im_we, exp_we, $time);
            end
            if (im_we === 1'b1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write actual=%h@%h required=none", im_wdata, im_addr);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wr_addr", im_addr, e.addr);
                    chk("wr_data", im_wdata, e.data);
                    chk("wr_count", {16'd0, word_count}, 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        reset_n = 1; flush = 0; in_valid = 0; in_kind = 0; in_rs = 0; in_rt = 0;
        in_rd = 0; in_shamt = 0; in_imm = 0;
        #1 reset_n = 0;
        #1 reset_chk("reset");
        repeat (2) @(negedge clk);
        reset_n = 1;
        started = 1;

        send(0, 1, 2, 3, 0, 0);
        do_flush();
        send(8, 0, 1, 0, 0, 32'h0000_1234);
        send(10, 4, 0, 0, 0, 32'h0000_FFFE);
        send(9, 0, 0, 0, 0, 32'h0000_0C03);
        do_flush();
        send(11, 0, 8, 0, 0, 32'hDEAD_BEEF);
        send(1, 5, 6, 7, 0, 0);
        do_flush();

        for (int i = 0; i < DEPTH; i++) send(3, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0);
        do_flush();
        send(3, 0, 0, 0, 0, 0);
        do_flush();

        for (int i = 0; i < DEPTH - 1; i++) send(3, 0, 0, 0, 0, 0);
        send(11, 0, 9, 0, 0, 32'h1234_5678);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        do_flush();
        send(15, 1, 1, 1, 1, 0);
        do_flush();

        send(11, 0, 3, 0, 0, 32'hCAFE_F00D);
        #2 reset_n = 0;
        model_clear();
        #1 reset_chk("midli");
        step(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        send(0, 7, 8, 9, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? 11 : int'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 24) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
